// File: rtl/ahb3lite_interconnect_slave_arbiter.sv
// ahb3lite_interconnect_slave_arbiter: per-slave grant arbiter, highest priority wins, round-robin on ties.
// Ports: HCLK/HRESET clock and sync active-high reset; mst_req/mst_priority/mst_can_switch per-master
// request, 3-bit priority (7 highest) and release permission; slv_HREADY slave ready;
// master_granted registered one-hot grant, granted_master owner/parked index, grant_valid owner present.
// Optional AHB3LITE_ARB_AGING_EN adds per-master wait counters that lift a starved master to priority 8.
module ahb3lite_interconnect_slave_arbiter #(
  parameter int MASTERS = 3,
  parameter int MAX_WAIT = 16,
  localparam int IW = MASTERS > 1 ? $clog2(MASTERS) : 1
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [MASTERS-1:0]   mst_req,
  input  logic [MASTERS*3-1:0] mst_priority,
  input  logic [MASTERS-1:0]   mst_can_switch,
  input  logic                 slv_HREADY,
  output logic [MASTERS-1:0]   master_granted,
  output logic [IW-1:0]        granted_master,
  output logic                 grant_valid
);
  logic [IW-1:0] owner_q, owner_d, win;
  logic valid_q, valid_d, arb_en, found;
  logic [MASTERS-1:0] gnt_q, gnt_d, aged;
  logic [3:0] best, eff;
  assign arb_en = slv_HREADY & (~valid_q | mst_can_switch[owner_q]);
  // Search starts just after the owner and ends on it; strict '>' keeps the earliest
  // candidate in that order, so the owner only wins a tie when nobody else has its priority.
  always_comb begin
    win = owner_q;
    best = '0;
    found = 1'b0;
    eff = '0;
    for (int k = 1; k <= MASTERS; k++) begin
      eff = aged[(int'(owner_q) + k) % MASTERS] ? 4'd8
          : {1'b0, mst_priority[3*((int'(owner_q) + k) % MASTERS) +: 3]};
      if (mst_req[(int'(owner_q) + k) % MASTERS] && (!found || eff > best)) begin
        found = 1'b1;
        best = eff;
        win = IW'((int'(owner_q) + k) % MASTERS);
      end
    end
  end
  always_comb begin
    owner_d = owner_q;
    valid_d = valid_q;
    gnt_d = gnt_q;
    if (arb_en) begin
      owner_d = found ? win : owner_q;
      valid_d = found;
      gnt_d = found ? MASTERS'(1) << win : '0;
    end
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      owner_q <= '0;
      valid_q <= 1'b0;
      gnt_q <= '0;
    end else begin
      owner_q <= owner_d;
      valid_q <= valid_d;
      gnt_q <= gnt_d;
    end
  end
`ifdef AHB3LITE_ARB_AGING_EN
  logic [7:0] wait_q [MASTERS];
  always_comb begin
    aged = '0;
    for (int i = 0; i < MASTERS; i++) aged[i] = wait_q[i] == 8'(MAX_WAIT);
  end
  // Counts only cycles where an arbitration actually happened and this master lost it.
  always_ff @(posedge HCLK) begin
    for (int i = 0; i < MASTERS; i++) begin
      if (HRESET || !mst_req[i] || (arb_en && win == IW'(i)))
        wait_q[i] <= '0;
      else if (arb_en && wait_q[i] != 8'(MAX_WAIT))
        wait_q[i] <= wait_q[i] + 8'd1;
    end
  end
`else
  assign aged = '0;
`endif
  assign master_granted = gnt_q;
  assign granted_master = owner_q;
  assign grant_valid = valid_q;
endmodule

// File: tb/tb_ahb3lite_interconnect_slave_arbiter.sv
// tb_ahb3lite_interconnect_slave_arbiter: directed checks of grant, rotation, hold, parking and aging.
module tb_ahb3lite_interconnect_slave_arbiter;
  logic clk = 1'b0, rst;
  logic [2:0] req, cs, gnt;
  logic [8:0] pri;
  logic rdy, valid;
  logic [1:0] gm;
  int n_tests = 0, n_fail = 0;
  ahb3lite_interconnect_slave_arbiter #(.MASTERS(3), .MAX_WAIT(4)) dut (
    .HCLK(clk), .HRESET(rst), .mst_req(req), .mst_priority(pri), .mst_can_switch(cs),
    .slv_HREADY(rdy), .master_granted(gnt), .granted_master(gm), .grant_valid(valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic state(input string tag, input int g, input int m, input int v);
    chk({tag, ".gnt"}, int'(gnt), g);
    chk({tag, ".idx"}, int'(gm), m);
    chk({tag, ".vld"}, int'(valid), v);
  endtask
  task automatic do_reset();
    rst = 1'b1; req = '0; cs = '0; rdy = 1'b1; pri = '0;
    tick();
    rst = 1'b0;
  endtask
  initial begin
    bit aging;
`ifdef AHB3LITE_ARB_AGING_EN
    aging = 1'b1;
`else
    aging = 1'b0;
`endif
    rst = 1'b1; req = 3'b111; cs = '0; rdy = 1'b1; pri = '0;
    tick(); state("rst1", 0, 0, 0);
    tick(); state("rst2", 0, 0, 0);
    rst = 1'b0;
    tick(); state("release", 3'b010, 1, 1);
    do_reset();
    req = 3'b101; pri = {3'd5, 3'd0, 3'd2};
    tick(); state("prio", 3'b100, 2, 1);
    do_reset();
    req = 3'b111; pri = {3'd3, 3'd3, 3'd3};
    tick(); state("rr0", 3'b010, 1, 1);
    cs = 3'b111;
    tick(); state("rr1", 3'b100, 2, 1);
    tick(); state("rr2", 3'b001, 0, 1);
    tick(); state("rr3", 3'b010, 1, 1);
    cs = '0; req = 3'b110; pri = {3'd7, 3'd3, 3'd3};
    for (int i = 0; i < 6; i++) begin
      tick(); state($sformatf("hold%0d", i), 3'b010, 1, 1);
    end
    cs = 3'b010; rdy = 1'b0;
    tick(); state("notready", 3'b010, 1, 1);
    rdy = 1'b1;
    tick(); state("switch", 3'b100, 2, 1);
    req = '0; cs = 3'b100;
    tick(); state("park", 0, 2, 0);
    tick(); state("park2", 0, 2, 0);
    do_reset();
    req = 3'b011; pri = {3'd0, 3'd7, 3'd0}; cs = 3'b111;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (aging && i % 5 == 4) state($sformatf("age%0d", i), 3'b001, 0, 1);
      else state($sformatf("age%0d", i), 3'b010, 1, 1);
    end
    rst = 1'b1;
    tick(); state("midrst", 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
